// File: rtl/alu_issue_sched.sv
// Round-robin scheduler sharing one ALU among NUM_REQ operand sources over a toggle/ready handshake.
// Define ALU_SCHED_TMO_EN to enable the per-wait-state handshake timeout and sticky aluErr.
module alu_issue_sched #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned SYNC_STG = 2,
    parameter int unsigned TMO_CYC  = 255,
    localparam int unsigned OP_W    = 164,
    localparam int unsigned RSP_W   = 130
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_REQ-1:0]      reqValid,
    input  logic [NUM_REQ*OP_W-1:0] reqOp,
    output logic [NUM_REQ-1:0]      reqAck,
    output logic [NUM_REQ-1:0]      rspValid,
    output logic [RSP_W-1:0]        rsp,
    output logic [OP_W-1:0]         aluOp,
    output logic                    aluReadyIn,
    output logic                    aluTriggerIn,
    input  logic                    aluTriggerOut,
    input  logic                    aluReadyOut,
    input  logic [RSP_W-1:0]        aluRsp,
    output logic                    aluErr
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] KICK      = 2'd1;
    localparam logic [1:0] WAIT_TRIG = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]          state;
    logic [SYNC_STG-1:0] trig_sync;
    logic [SYNC_STG-1:0] rdy_sync;
    logic                trig_s;
    logic                rdy_s;
    logic                trig_ref;
    logic                seen_low;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last;
    logic [NUM_REQ-1:0]  grant_oh;
    logic                arb_found;
    logic [GW-1:0]       arb_idx;
    logic [GW-1:0]       cand;

`ifdef ALU_SCHED_TMO_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO_CYC - 1);
    logic [7:0] wait_cnt;
    logic       tmo_hit;
    assign tmo_hit = (wait_cnt == TMO_LIM);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            trig_sync <= '0;
            rdy_sync  <= '0;
        end else begin
            trig_sync <= {trig_sync[SYNC_STG-2:0], aluTriggerOut};
            rdy_sync  <= {rdy_sync[SYNC_STG-2:0], aluReadyOut};
        end
    end

    assign trig_s = trig_sync[SYNC_STG-1];
    assign rdy_s  = rdy_sync[SYNC_STG-1];

    // Scan starts just after the last completed grant, so each requester waits at most NUM_REQ-1 ops.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last) + k) % NUM_REQ);
            if (!arb_found && reqValid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            grant_oh[i] = (grant == GW'(i));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            grant        <= '0;
            last         <= GW'(NUM_REQ - 1);
            aluOp        <= '0;
            rsp          <= '0;
            reqAck       <= '0;
            rspValid     <= '0;
            aluReadyIn   <= 1'b0;
            aluTriggerIn <= 1'b0;
            trig_ref     <= 1'b0;
            seen_low     <= 1'b0;
`ifdef ALU_SCHED_TMO_EN
            wait_cnt     <= '0;
            aluErr       <= 1'b0;
`endif
        end else begin
            reqAck   <= '0;
            rspValid <= '0;
`ifdef ALU_SCHED_TMO_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant <= arb_idx;
                        aluOp <= reqOp[32'(arb_idx)*OP_W +: OP_W];
                        state <= KICK;
                    end
                end
                KICK: begin
                    aluTriggerIn <= ~aluTriggerIn;
                    trig_ref     <= trig_s;
                    state        <= WAIT_TRIG;
`ifdef ALU_SCHED_TMO_EN
                    wait_cnt     <= '0;
`endif
                end
                WAIT_TRIG: begin
                    if (trig_s != trig_ref) begin
                        aluReadyIn <= 1'b1;
                        reqAck     <= grant_oh;
                        seen_low   <= 1'b0;
                        state      <= WAIT_DONE;
`ifdef ALU_SCHED_TMO_EN
                        wait_cnt   <= '0;
                    end else if (tmo_hit) begin
                        aluErr     <= 1'b1;
                        aluReadyIn <= 1'b0;
                        state      <= IDLE;
`endif
                    end
                end
                WAIT_DONE: begin
                    // readyOut must be seen low once before a high counts, so a level left over
                    // from the previous op cannot complete this one.
                    if (!rdy_s)
                        seen_low <= 1'b1;
                    if (rdy_s && seen_low) begin
                        rsp        <= aluRsp;
                        rspValid   <= grant_oh;
                        aluReadyIn <= 1'b0;
                        last       <= grant;
                        state      <= IDLE;
`ifdef ALU_SCHED_TMO_EN
                    end else if (tmo_hit) begin
                        aluErr     <= 1'b1;
                        aluReadyIn <= 1'b0;
                        state      <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ALU_SCHED_TMO_EN
    assign aluErr = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched with a behavioural ALU handshake model.
`timescale 1ns/1ps
module tb_alu_issue_sched;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned SYNC_STG = 2;
    localparam int unsigned TMO_CYC  = 16;
    localparam int unsigned OP_W     = 164;
    localparam int unsigned RSP_W    = 130;

    logic                    clk = 1'b0;
    logic                    resetN;
    logic [NUM_REQ-1:0]      reqValid;
    logic [NUM_REQ*OP_W-1:0] reqOp;
    logic [NUM_REQ-1:0]      reqAck;
    logic [NUM_REQ-1:0]      rspValid;
    logic [RSP_W-1:0]        rsp;
    logic [OP_W-1:0]         aluOp;
    logic                    aluReadyIn;
    logic                    aluTriggerIn;
    logic                    aluTriggerOut;
    logic                    aluReadyOut;
    logic [RSP_W-1:0]        aluRsp;
    logic                    aluErr;

    always #5 clk = ~clk;

    alu_issue_sched #(
        .NUM_REQ (NUM_REQ),
        .SYNC_STG(SYNC_STG),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .reqValid     (reqValid),
        .reqOp        (reqOp),
        .reqAck       (reqAck),
        .rspValid     (rspValid),
        .rsp          (rsp),
        .aluOp        (aluOp),
        .aluReadyIn   (aluReadyIn),
        .aluTriggerIn (aluTriggerIn),
        .aluTriggerOut(aluTriggerOut),
        .aluReadyOut  (aluReadyOut),
        .aluRsp       (aluRsp),
        .aluErr       (aluErr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] mk_op(input logic [3:0] t, input logic [31:0] sd,
                                              input logic [31:0] d4, input logic [31:0] d3,
                                              input logic [31:0] d2, input logic [31:0] d1);
        return {t, sd, d4, d3, d2, d1};
    endfunction

    // ALU behaviour: dOut1=d1+d2, dOut2=d3^d4, cpsr=type, srcDst passed through, w=1, m=0.
    function automatic logic [RSP_W-1:0] alu_calc(input logic [OP_W-1:0] op);
        return {1'b0, 1'b1, op[159:128], {28'd0, op[163:160]}, op[127:96] ^ op[95:64], op[63:32] + op[31:0]};
    endfunction

    typedef struct { int unsigned who; logic [OP_W-1:0] op; } ack_t;
    typedef struct { int unsigned who; logic [RSP_W-1:0] val; } rsp_t;

    ack_t            ack_q[$];
    rsp_t            rsp_q[$];
    logic [OP_W-1:0] pend0[$];
    logic [OP_W-1:0] pend1[$];

    task automatic issue(input int unsigned who, input logic [OP_W-1:0] op, input bit queue_it);
        ack_t a;
        rsp_t r;
        a.who = who; a.op = op;
        r.who = who; r.val = alu_calc(op);
        ack_q.push_back(a);
        rsp_q.push_back(r);
        if (queue_it) begin
            if (who == 0) pend0.push_back(op);
            else          pend1.push_back(op);
        end
    endtask

    // Called on negedges: retire the acked op, then present the next pending one.
    task automatic drive_reqs();
        if (reqAck[0] && pend0.size() > 0) pend0.delete(0);
        if (reqAck[1] && pend1.size() > 0) pend1.delete(0);
        reqValid[0]         = (pend0.size() > 0);
        reqValid[1]         = (pend1.size() > 0);
        reqOp[OP_W-1:0]     = (pend0.size() > 0) ? pend0[0] : '0;
        reqOp[2*OP_W-1:OP_W] = (pend1.size() > 0) ? pend1[0] : '0;
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((pend0.size() + pend1.size() + ack_q.size() + rsp_q.size()) > 0 && n < budget) begin
            @(negedge clk);
            drive_reqs();
            n++;
        end
        check({tag, "_outstanding"}, pend0.size() + pend1.size() + ack_q.size() + rsp_q.size(), 0);
        @(negedge clk);
        drive_reqs();
    endtask

    // Monitor: counts trigger toggles and pops the scoreboard on ack/rsp pulses.
    int                 trig_cnt = 0;
    logic               prev_trig = 1'b0;
    ack_t               ma;
    rsp_t               mr;
    logic [NUM_REQ-1:0] exp_oh;

    always @(posedge clk) begin
        #1;
        if (resetN === 1'b1) begin
            if (aluTriggerIn !== prev_trig) trig_cnt++;
            prev_trig = aluTriggerIn;
            if (reqAck !== '0 || rspValid !== '0)
                check("ack_rsp_excl", (reqAck != '0) && (rspValid != '0), 0);
            if (reqAck !== '0) begin
                if (ack_q.size() > 0) begin
                    ma = ack_q.pop_front();
                    exp_oh = '0;
                    exp_oh[ma.who] = 1'b1;
                    check("ack_who", reqAck, exp_oh);
                    check("ack_op", aluOp, ma.op);
                end else begin
                    check("ack_unexpected", reqAck, 0);
                end
            end
            if (rspValid !== '0) begin
                if (rsp_q.size() > 0) begin
                    mr = rsp_q.pop_front();
                    exp_oh = '0;
                    exp_oh[mr.who] = 1'b1;
                    check("rsp_who", rspValid, exp_oh);
                    check("rsp_data", rsp, mr.val);
                end else begin
                    check("rsp_unexpected", rspValid, 0);
                end
            end
        end else begin
            prev_trig = 1'b0;
        end
    end

    // ALU model: answers a trigger toggle with its own toggle, then result/ready on aluReadyIn.
    bit alu_mute  = 1'b0;
    bit alu_stale = 1'b0;
    int ms;
    int scnt;
    logic ptrig;

    initial begin
        ms = 0; scnt = 0; ptrig = 1'b0;
        aluTriggerOut = 1'b0; aluReadyOut = 1'b0; aluRsp = '0;
        forever begin
            @(negedge clk);
            if (resetN !== 1'b1) begin
                ms = 0; ptrig = 1'b0;
                aluTriggerOut = 1'b0; aluReadyOut = 1'b0;
            end else begin
                case (ms)
                    0: if (aluTriggerIn !== ptrig) begin
                        ptrig = aluTriggerIn;
                        if (!alu_mute) begin
                            aluTriggerOut = ~aluTriggerOut;
                            if (alu_stale) begin
                                aluReadyOut = 1'b1;
                                aluRsp = ~alu_calc(aluOp);
                                scnt = 3;
                                ms = 1;
                            end else begin
                                ms = 2;
                            end
                        end
                    end
                    1: begin
                        scnt--;
                        if (scnt == 0) begin
                            aluReadyOut = 1'b0;
                            ms = 2;
                        end
                    end
                    2: if (aluReadyIn) begin
                        aluRsp = alu_calc(aluOp);
                        aluReadyOut = 1'b1;
                        ms = 3;
                    end
                    3: if (!aluReadyIn) begin
                        aluReadyOut = 1'b0;
                        ms = 0;
                    end
                    default: ms = 0;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int   t0;
    int   lat;
    int   n;
    logic [OP_W-1:0] op6;

    initial begin
        resetN = 1'b0; reqValid = '0; reqOp = '0;
        repeat (3) @(negedge clk);
        check("rst_reqAck", reqAck, 0);
        check("rst_rspValid", rspValid, 0);
        check("rst_rsp", rsp, 0);
        check("rst_aluOp", aluOp, 0);
        check("rst_ctrl", {aluReadyIn, aluTriggerIn, aluErr}, 0);
        resetN = 1'b1;

        // Both requesters busy from reset: grants must go 0,1,0,1.
        @(negedge clk);
        issue(0, mk_op(4'h2, 32'hA0, 32'h1, 32'h2, 32'h10, 32'h20), 1'b1);
        issue(1, mk_op(4'h3, 32'hB0, 32'h3, 32'h4, 32'h30, 32'h40), 1'b1);
        issue(0, mk_op(4'h4, 32'hC0, 32'h5, 32'h6, 32'h50, 32'h60), 1'b1);
        issue(1, mk_op(4'h5, 32'hD0, 32'h7, 32'h8, 32'h70, 32'h80), 1'b1);
        drive_reqs();
        drain("rr", 300);

        // Single op from req0: 5+7, ack latency and one trigger toggle.
        t0 = trig_cnt;
        issue(0, mk_op(4'h1, 32'h11, 32'h0, 32'h0, 32'd7, 32'd5), 1'b1);
        drive_reqs();
        lat = 0;
        while (reqAck[0] !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        // grant edge, KICK edge, model answers on the next negedge, SYNC_STG flops, registered ack
        check("t1_ack_lat", lat, 3 + SYNC_STG);
        drain("single", 100);
        check("t1_dout1", rsp[31:0], 12);
        check("t1_toggles", trig_cnt - t0, 1);

        // Stale readyOut still high from the trigger toggle must not complete the op.
        alu_stale = 1'b1;
        issue(0, mk_op(4'h6, 32'h66, 32'hF0F0, 32'h0F0F, 32'd100, 32'd23), 1'b1);
        drive_reqs();
        drain("stale", 100);
        alu_stale = 1'b0;

        // Req1 withdraws its request right after being granted.
        op6 = mk_op(4'h7, 32'h77, 32'h9, 32'hA, 32'd1000, 32'd234);
        issue(1, op6, 1'b0);
        reqOp[2*OP_W-1:OP_W] = op6;
        reqValid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        reqValid = '0;
        reqOp = '0;
        drain("drop_valid", 100);

        // Reset while waiting for the result: outputs clear at once, the op is forgotten.
        issue(0, mk_op(4'h8, 32'h88, 32'h1, 32'h1, 32'd8, 32'd8), 1'b1);
        drive_reqs();
        n = 0;
        while (ack_q.size() > 0 && n < 50) begin
            @(negedge clk);
            drive_reqs();
            n++;
        end
        check("t4_acked", ack_q.size(), 0);
        #2 resetN = 1'b0;
        #1;
        check("t4_reqAck", reqAck, 0);
        check("t4_rspValid", rspValid, 0);
        check("t4_rsp", rsp, 0);
        check("t4_aluOp", aluOp, 0);
        check("t4_ctrl", {aluReadyIn, aluTriggerIn, aluErr}, 0);
        rsp_q.delete();
        pend0.delete();
        repeat (2) @(negedge clk);
        drive_reqs();
        resetN = 1'b1;
        @(negedge clk);
        issue(0, mk_op(4'h9, 32'h99, 32'h2, 32'h3, 32'd40, 32'd2), 1'b1);
        drive_reqs();
        drain("post_reset", 100);
        check("t4_post_dout1", rsp[31:0], 42);

`ifdef ALU_SCHED_TMO_EN
        // ALU never answers the trigger: timeout after TMO_CYC cycles in WAIT_TRIG.
        alu_mute = 1'b1;
        t0 = trig_cnt;
        reqOp[OP_W-1:0] = mk_op(4'hA, 32'hAA, 32'h0, 32'h0, 32'd1, 32'd1);
        reqValid = 2'b01;
        lat = 0;
        while (aluErr !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t5_err_cycles", lat, 2 + TMO_CYC);
        @(negedge clk);
        reqValid = '0;
        reqOp = '0;
        repeat (5) @(negedge clk);
        check("t5_err_sticky", aluErr, 1);
        check("t5_readyin", aluReadyIn, 0);
        check("t5_one_kick", trig_cnt - t0, 1);
        alu_mute = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
